counter_timer_ctrl: RTL and testbench
=====================================

Name: counter_timer_ctrl

Overview:
- Sequencing controller for one n-bit up/down counter (counter_behavioral port set: en, count_up, load, set, count).
- Turns the counter into a programmable interval timer: loads a start value, enables counting, detects the terminal value, then stops (one-shot) or reloads (periodic).
- Raises a done pulse and a sticky irq. The counter is instantiated next to this block and is not part of it.

Parameters:
- n, 4, counter width; must match the attached counter.
- PS_W, 4, prescaler width; used only when CNT_CTRL_PRESCALE_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- res  in  1  asynchronous, active-high reset.
- start  in  1  begin a timing run; sampled only in IDLE.
- stop  in  1  abort the run; sampled in every state.
- mode_periodic  in  1  1 = reload on terminal, 0 = one-shot; latched at start.
- dir_up  in  1  1 = count 0 up to limit, 0 = count limit down to 0; latched at start.
- limit  in  n  terminal/start value; latched at start.
- irq_clr  in  1  clears irq.
- count  in  n  current counter value (feedback from the counter).
- cnt_en  out  1  counter enable.
- cnt_up  out  1  counter direction; equals the latched dir_up.
- cnt_load  out  1  counter synchronous load strobe.
- cnt_set  out  n  counter load value.
- busy  out  1  high in LOAD and RUN.
- done  out  1  one-cycle terminal pulse.
- irq  out  1  sticky terminal flag.

Behaviour:
- Reset (asynchronous, any time including mid-run):
  - state = IDLE; latched dir/mode/limit = 0; irq = 0.
  - All outputs are 0 while res is high and in the first cycle after release.
  - The counter state is not touched by this block.
- States: IDLE, LOAD, RUN. term = latched dir_up ? latched limit : 0.
- IDLE:
  - cnt_en = cnt_load = busy = 0.
  - start=1 and stop=0: latch dir_up, mode_periodic and limit; go to LOAD.
  - start=1 and stop=1: stop wins; stay in IDLE.
- LOAD (always exactly 1 cycle):
  - cnt_load = 1, cnt_en = 1, cnt_set = dir_up ? 0 : limit (latched values).
  - Next state is RUN, unless stop=1, in which case go to IDLE.
- RUN: cnt_load = 0; cnt_en = (count != term) && !stop, combinational gate so the counter never passes term.
  - count == term and stop=0: done = 1 this cycle; irq is set at the edge; next state is LOAD if periodic, else IDLE.
  - stop=1: go to IDLE; no done, no irq. Stop beats terminal in the same cycle.
- Timing: start sampled at edge E0.
  - LOAD runs in cycle 1; RUN from cycle 2.
  - done is high in cycle limit+2.
  - Periodic period = limit+2 cycles (one LOAD, limit counting cycles, one terminal cycle).
  - limit=0 gives done in cycle 2, period 2.
- start while busy: ignored; no restart. Changes to limit/dir/mode while busy: ignored until the next start.
- irq:
  - Set at the edge that ends a done cycle; held until irq_clr.
  - If set and clear happen in the same cycle, set wins.
- cnt_up = latched dir_up in all states, so the counter direction is stable before LOAD.

Optional Feature:
- CNT_CTRL_PRESCALE_EN defined:
  - Adds input prescale[PS_W-1:0], latched at start.
  - Adds a PS_W-bit prescaler that is cleared in LOAD. In RUN, the counter advances only on prescaler tick cycles: cnt_en also requires ps == prescale; ps wraps to 0 on the tick and increments otherwise.
  - Terminal detection and stop behave as without the macro.
  - Period = limit*(prescale+1)+2; prescale=0 gives identical timing to the macro-off build.
- CNT_CTRL_PRESCALE_EN undefined: no port, no prescaler logic; the counter advances every RUN cycle.

Test Plan:
- Bench: n=4, counter_behavioral attached with res_n = ~res.
- One-shot up, limit=5: start pulse at E0 -> cnt_load high cycle 1; count 0..5; done high only in cycle 7; irq=1 afterwards; count holds 5; busy=0 from cycle 8.
- Periodic down, limit=3: count runs 3,2,1,0 then reloads to 3. done pulses every 5 cycles for 4 periods. start pulses while busy have no effect.
- stop mid-run at count=2 (up, limit=9) -> IDLE next edge; count frozen at 2; no done, irq stays 0. stop coincident with terminal -> no done.
- irq handshake: irq_clr after a one-shot run -> irq=0 next edge. irq_clr coincident with done -> irq stays 1.
- Edges and reset:
  - limit=0 periodic -> done every 2 cycles.
  - limit=15 up -> done in cycle 17, no wrap to 0.
  - res pulsed mid-RUN -> all outputs 0 immediately, state IDLE.
- CNT_CTRL_PRESCALE_EN with prescale=2, limit=4 up -> counter steps every 3rd RUN cycle; done in cycle 14.

Source files
------------

// File: rtl/counter_timer_ctrl.sv
// counter_timer_ctrl: sequences an external n-bit up/down counter as a
// programmable interval timer (one-shot or periodic) with done pulse and
// sticky irq.
// Optional build macro CNT_CTRL_PRESCALE_EN adds a latched prescale input and
// a PS_W-bit prescaler that slows counting in RUN.
module counter_timer_ctrl #(
    parameter int unsigned n = 4
`ifdef CNT_CTRL_PRESCALE_EN
    , parameter int unsigned PS_W = 4
`endif
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    input  logic          stop,
    input  logic          mode_periodic,
    input  logic          dir_up,
    input  logic [n-1:0]  limit,
`ifdef CNT_CTRL_PRESCALE_EN
    input  logic [PS_W-1:0] prescale,
`endif
    input  logic          irq_clr,
    input  logic [n-1:0]  count,
    output logic          cnt_en,
    output logic          cnt_up,
    output logic          cnt_load,
    output logic [n-1:0]  cnt_set,
    output logic          busy,
    output logic          done,
    output logic          irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         dir_q;
    logic         mode_q;
    logic [n-1:0] limit_q;
    logic         irq_q;
    logic [n-1:0] term;
    logic         at_term;
    logic         tick;
    logic         launch;

`ifdef CNT_CTRL_PRESCALE_EN
    logic [PS_W-1:0] prescale_q;
    logic [PS_W-1:0] ps;
`endif

    assign term    = dir_q ? limit_q : '0;
    assign at_term = (count == term);
    assign launch  = (state == IDLE) && start && !stop;

    // Direction and load value come from the latched run settings so the
    // counter sees a stable direction before LOAD.
    assign cnt_up  = dir_q;
    assign cnt_set = dir_q ? '0 : limit_q;
    assign irq     = irq_q;

`ifdef CNT_CTRL_PRESCALE_EN
    assign tick = (ps == prescale_q);
`else
    assign tick = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Run settings captured on an accepted start; ignored while busy
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            limit_q <= '0;
        end else if (launch) begin
            dir_q   <= dir_up;
            mode_q  <= mode_periodic;
            limit_q <= limit;
        end
    end

    // Sticky interrupt: a terminal cycle overrides a simultaneous clear
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            irq_q <= 1'b0;
        end else if (done) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

`ifdef CNT_CTRL_PRESCALE_EN
    // Prescaler: cleared in LOAD, wraps on each tick during RUN
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            prescale_q <= '0;
            ps         <= '0;
        end else begin
            if (launch) begin
                prescale_q <= prescale;
            end
            if (state == LOAD) begin
                ps <= '0;
            end else if (state == RUN) begin
                ps <= tick ? '0 : ps + 1'b1;
            end
        end
    end
`endif

    // Next-state and counter control; cnt_en is gated combinationally so the
    // counter never steps past the terminal value
    always_comb begin
        state_nxt = state;
        cnt_en    = 1'b0;
        cnt_load  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                busy      = 1'b1;
                cnt_load  = 1'b1;
                cnt_en    = 1'b1;
                state_nxt = stop ? IDLE : RUN;
            end
            RUN: begin
                busy   = 1'b1;
                cnt_en = !at_term && !stop && tick;
                if (stop) begin
                    state_nxt = IDLE;
                end else if (at_term) begin
                    done      = 1'b1;
                    state_nxt = mode_q ? LOAD : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Scoreboard bench for counter_timer_ctrl with a behavioural up/down counter
// attached (counter reset tied to the controller reset).
module tb_counter_timer_ctrl;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         res = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         mode_periodic = 1'b0;
    logic         dir_up = 1'b0;
    logic         irq_clr = 1'b0;
    logic [N-1:0] limit = '0;
    logic [N-1:0] count;
    logic [N-1:0] cnt_set;
    logic         cnt_en, cnt_up, cnt_load, busy, done, irq;
`ifdef CNT_CTRL_PRESCALE_EN
    logic [3:0]   prescale = '0;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;

    typedef struct {
        int           cyc;
        logic [N-1:0] cnt;
        string        tag;
    } exp_t;
    exp_t sb[$];

    counter_timer_ctrl #(
        .n(N)
`ifdef CNT_CTRL_PRESCALE_EN
        , .PS_W(4)
`endif
    ) dut (
        .clk(clk),
        .res(res),
        .start(start),
        .stop(stop),
        .mode_periodic(mode_periodic),
        .dir_up(dir_up),
        .limit(limit),
`ifdef CNT_CTRL_PRESCALE_EN
        .prescale(prescale),
`endif
        .irq_clr(irq_clr),
        .count(count),
        .cnt_en(cnt_en),
        .cnt_up(cnt_up),
        .cnt_load(cnt_load),
        .cnt_set(cnt_set),
        .busy(busy),
        .done(done),
        .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Attached counter: synchronous load has priority over enable
    always_ff @(posedge clk or posedge res) begin
        if (res) count <= '0;
        else if (cnt_load) count <= cnt_set;
        else if (cnt_en) count <= cnt_up ? count + 1'b1 : count - 1'b1;
    end

    // Monitor: every done pulse must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!res && done) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL spurious_done cyc=%0d count=%0d expected no done", cyc, count);
            end else begin
                e = sb.pop_front();
                if (cyc != e.cyc || count != e.cnt) begin
                    failures++;
                    $display("FAIL %s done at cyc=%0d count=%0d, expected cyc=%0d count=%0d",
                             e.tag, cyc, count, e.cyc, e.cnt);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input logic [N-1:0] c, input string tag);
        exp_t e;
        e.cyc = t0 + k - 1;
        e.cnt = c;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Issue a start; afterwards we sit in cycle 1 (posedge E0 + #1)
    task automatic start_run(input logic up, input logic per, input logic [N-1:0] lim);
        dir_up = up;
        mode_periodic = per;
        limit = lim;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    // Advance to posedge+#1 at the beginning of cycle k of the current run
    task automatic goto(input int k);
        int target;
        int guard;
        target = t0 + k - 1;
        guard = 0;
        while (cyc < target && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != target) begin
            checks++;
            failures++;
            $display("FAIL schedule cyc=%0d expected=%0d", cyc, target);
        end
    endtask

    function automatic logic [31:0] outs();
        return {20'd0, cnt_en, cnt_up, cnt_load, busy, done, irq, 2'b00, cnt_set};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset hold and first cycle after release
        repeat (2) @(negedge clk);
        chk("reset_hold_outputs", outs(), 32'd0);
        @(posedge clk);
        #1;
        res = 1'b0;
        @(negedge clk);
        chk("reset_release_outputs", outs(), 32'd0);

        // One-shot up, limit 5: done in cycle 7
        @(posedge clk);
        #1;
        start_run(1'b1, 1'b0, 4'd5);
        push(7, 4'd5, "oneshot_up5");
        goto(1);
        @(negedge clk);
        chk("load_strobe", {cnt_load, cnt_en, busy, cnt_up}, 32'hF);
        chk("load_value", cnt_set, 32'd0);
        goto(2);
        @(negedge clk);
        chk("run_first_count", count, 32'd0);
        goto(8);
        @(negedge clk);
        chk("oneshot_idle_busy", busy, 32'd0);
        chk("oneshot_irq_set", irq, 32'd1);
        chk("oneshot_count_hold", count, 32'd5);

        // irq clear after one-shot
        goto(9);
        irq_clr = 1'b1;
        @(posedge clk);
        #1;
        irq_clr = 1'b0;
        @(negedge clk);
        chk("irq_cleared", irq, 32'd0);

        // start and stop together in IDLE: stop wins
        @(posedge clk);
        #1;
        start = 1'b1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        chk("stop_beats_start", busy, 32'd0);

        // Periodic down, limit 3: done in cycles 5,10,15,20
        @(posedge clk);
        #1;
        start_run(1'b0, 1'b1, 4'd3);
        for (int i = 0; i < 4; i++) push(5 + 5 * i, 4'd0, "periodic_down3");
        goto(3);
        start = 1'b1;
        dir_up = 1'b1;
        limit = 4'd7;
        mode_periodic = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_start_ignored_dir", cnt_up, 32'd0);
        goto(7);
        @(negedge clk);
        chk("periodic_reload_value", count, 32'd3);
        goto(12);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        goto(21);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        @(negedge clk);
        chk("periodic_stopped", busy, 32'd0);
        @(posedge clk);
        #1;
        irq_clr = 1'b1;
        @(posedge clk);
        #1;
        irq_clr = 1'b0;
        @(negedge clk);
        chk("irq_cleared_2", irq, 32'd0);

        // Stop mid-run at count 2 (up, limit 9)
        @(posedge clk);
        #1;
        start_run(1'b1, 1'b0, 4'd9);
        goto(4);
        stop = 1'b1;
        @(negedge clk);
        chk("stop_count_at_2", count, 32'd2);
        chk("stop_gates_enable", cnt_en, 32'd0);
        @(posedge clk);
        #1;
        stop = 1'b0;
        goto(7);
        @(negedge clk);
        chk("stop_idle", busy, 32'd0);
        chk("stop_count_frozen", count, 32'd2);
        chk("stop_no_irq", irq, 32'd0);

        // Stop coincident with terminal (up, limit 2, terminal in cycle 4)
        @(posedge clk);
        #1;
        start_run(1'b1, 1'b0, 4'd2);
        goto(4);
        stop = 1'b1;
        @(negedge clk);
        chk("stop_term_count", count, 32'd2);
        chk("stop_term_no_done", done, 32'd0);
        @(posedge clk);
        #1;
        stop = 1'b0;
        @(negedge clk);
        chk("stop_term_idle_noirq", {busy, irq}, 32'd0);

        // irq_clr coincident with done: set wins (up, limit 1, done cycle 3)
        @(posedge clk);
        #1;
        start_run(1'b1, 1'b0, 4'd1);
        push(3, 4'd1, "oneshot_up1");
        goto(3);
        irq_clr = 1'b1;
        @(posedge clk);
        #1;
        irq_clr = 1'b0;
        @(negedge clk);
        chk("irq_set_beats_clear", irq, 32'd1);
        @(posedge clk);
        #1;
        irq_clr = 1'b1;
        @(posedge clk);
        #1;
        irq_clr = 1'b0;

        // limit 0 periodic: done every 2 cycles
        @(posedge clk);
        #1;
        start_run(1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 4; i++) push(2 + 2 * i, 4'd0, "periodic_limit0");
        goto(9);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        @(negedge clk);
        chk("limit0_stopped", busy, 32'd0);

        // limit 15 up: done in cycle 17, no wrap
        @(posedge clk);
        #1;
        start_run(1'b1, 1'b0, 4'd15);
        push(17, 4'd15, "oneshot_up15");
        goto(19);
        @(negedge clk);
        chk("limit15_no_wrap", count, 32'd15);
        chk("limit15_idle", busy, 32'd0);

        // Asynchronous reset mid-RUN
        @(posedge clk);
        #1;
        start_run(1'b1, 1'b0, 4'd9);
        goto(5);
        @(negedge clk);
        chk("pre_reset_busy", busy, 32'd1);
        #2;
        res = 1'b1;
        #1;
        chk("reset_async_outputs", outs(), 32'd0);
        @(posedge clk);
        #1;
        res = 1'b0;
        @(negedge clk);
        chk("reset_async_release", outs(), 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
